// File: rtl/quadrilatero_lsu_arbiter.sv
// quadrilatero_lsu_arbiter: round-robin arbiter sharing one load/store unit among N_REQ requesters
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_valid_i/instr/conf   per-requester instruction and CSR configuration
//   req_ready_o              one-hot grant, combinational in IDLE
//   req_done_o               one-hot 1-cycle completion pulse to the owner
//   lsu_busy_i               LSU busy
//   lsu_start_o              1-cycle start pulse to the LSU
//   lsu_instr_o/lsu_conf_o   registered issued instruction/configuration
//   owner_o, active_o        current or last owner, arbiter not idle
package quadrilatero_pkg;
    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  rd;
        logic [31:0] addr;
    } lsu_instr_t;
    typedef struct packed {
        logic [15:0] stride;
        logic [7:0]  n_rows;
    } lsu_conf_t;
endpackage

module quadrilatero_lsu_arbiter
    import quadrilatero_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_valid_i,
    input  lsu_instr_t       req_instr_i [N_REQ],
    input  lsu_conf_t        req_conf_i  [N_REQ],
    output logic [N_REQ-1:0] req_ready_o,
    output logic [N_REQ-1:0] req_done_o,
    input  logic             lsu_busy_i,
    output logic             lsu_start_o,
    output lsu_instr_t       lsu_instr_o,
    output lsu_conf_t        lsu_conf_o,
    output logic [IDX_W-1:0] owner_o,
    output logic             active_o
);
    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, RUN} state_t;
    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, gnt_idx;
    logic [IDX_W:0]   gnt_sum;
    logic [N_REQ-1:0] rot;
    logic             gnt_found, grant, finish;

    // Rotating the request vector by rr_ptr makes bit 0 the highest priority;
    // the first set bit j maps back to requester (rr_ptr + j) mod N_REQ.
    always_comb begin
        rot       = N_REQ'({req_valid_i, req_valid_i} >> rr_ptr_q);
        gnt_found = 1'b0;
        gnt_sum   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!gnt_found && rot[j]) begin
                gnt_found = 1'b1;
                gnt_sum   = {1'b0, rr_ptr_q} + (IDX_W+1)'(j);
            end
        end
        gnt_idx = IDX_W'(gnt_sum >= (IDX_W+1)'(N_REQ) ? gnt_sum - (IDX_W+1)'(N_REQ) : gnt_sum);
    end

    assign grant  = state_q == IDLE && !lsu_busy_i && gnt_found;
    // Busy low in WAIT_BUSY means the LSU finished without ever raising busy.
    assign finish = (state_q == WAIT_BUSY || state_q == RUN) && !lsu_busy_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = grant ? START : IDLE;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: state_d = lsu_busy_i ? RUN : IDLE;
            RUN:       state_d = lsu_busy_i ? RUN : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign req_ready_o = grant ? N_REQ'(1) << gnt_idx : '0;
    assign req_done_o  = finish ? N_REQ'(1) << owner_o : '0;
    assign lsu_start_o = state_q == START;
    assign active_o    = state_q != IDLE;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_o     <= '0;
            lsu_instr_o <= '0;
            lsu_conf_o  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_o     <= gnt_idx;
                rr_ptr_q    <= gnt_idx == IDX_W'(N_REQ-1) ? '0 : gnt_idx + 1'b1;
                lsu_instr_o <= req_instr_i[gnt_idx];
                lsu_conf_o  <= req_conf_i[gnt_idx];
            end
        end
    end

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_ready_o));
    a_done_onehot:  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_done_o));
    a_start_pulse:  assert property (@(posedge clk_i) disable iff (rst_i) lsu_start_o |=> !lsu_start_o);
endmodule

// File: tb/tb_quadrilatero_lsu_arbiter.sv
// tb_quadrilatero_lsu_arbiter: directed self-checking bench for a 2- and a 3-requester arbiter
module tb_quadrilatero_lsu_arbiter;
    import quadrilatero_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [1:0] a_valid, a_ready, a_done;
    lsu_instr_t a_instr [2];
    lsu_conf_t  a_conf  [2];
    logic       a_busy, a_start, a_active;
    lsu_instr_t a_linstr;
    lsu_conf_t  a_lconf;
    logic [0:0] a_owner;

    logic [2:0] b_valid, b_ready, b_done;
    lsu_instr_t b_instr [3];
    lsu_conf_t  b_conf  [3];
    logic       b_busy, b_start, b_active;
    lsu_instr_t b_linstr;
    lsu_conf_t  b_lconf;
    logic [1:0] b_owner;

    quadrilatero_lsu_arbiter #(.N_REQ(2)) u_a (
        .clk_i(clk), .rst_i(rst), .req_valid_i(a_valid), .req_instr_i(a_instr),
        .req_conf_i(a_conf), .req_ready_o(a_ready), .req_done_o(a_done),
        .lsu_busy_i(a_busy), .lsu_start_o(a_start), .lsu_instr_o(a_linstr),
        .lsu_conf_o(a_lconf), .owner_o(a_owner), .active_o(a_active)
    );

    quadrilatero_lsu_arbiter #(.N_REQ(3)) u_b (
        .clk_i(clk), .rst_i(rst), .req_valid_i(b_valid), .req_instr_i(b_instr),
        .req_conf_i(b_conf), .req_ready_o(b_ready), .req_done_o(b_done),
        .lsu_busy_i(b_busy), .lsu_start_o(b_start), .lsu_instr_o(b_linstr),
        .lsu_conf_o(b_lconf), .owner_o(b_owner), .active_o(b_active)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // One transaction: grant g in IDLE, start, nbusy busy cycles, done pulse.
    task automatic a_txn(input int g, input int nbusy);
        a_busy = 1'b0;
        #1;
        check("a_ready", a_ready, 64'(1) << g);
        cyc();
        check("a_start", a_start, 1);
        check("a_owner", a_owner, g);
        check("a_instr", a_linstr, a_instr[g]);
        check("a_conf", a_lconf, a_conf[g]);
        check("a_ready_busy", a_ready, 0);
        cyc();
        for (int i = 0; i < nbusy; i++) begin
            a_busy = 1'b1;
            #1;
            check("a_done_early", a_done, 0);
            check("a_start_once", a_start, 0);
            cyc();
        end
        a_busy = 1'b0;
        #1;
        check("a_done", a_done, 64'(1) << g);
        check("a_ready_done", a_ready, 0);
        cyc();
        check("a_done_pulse", a_done, 0);
        check("a_idle", a_active, 0);
    endtask

    task automatic b_txn(input int g, input int nbusy);
        b_busy = 1'b0;
        #1;
        check("b_ready", b_ready, 64'(1) << g);
        cyc();
        check("b_start", b_start, 1);
        check("b_owner", b_owner, g);
        check("b_instr", b_linstr, b_instr[g]);
        check("b_conf", b_lconf, b_conf[g]);
        cyc();
        for (int i = 0; i < nbusy; i++) begin
            b_busy = 1'b1;
            #1;
            check("b_done_early", b_done, 0);
            check("b_start_once", b_start, 0);
            cyc();
        end
        b_busy = 1'b0;
        #1;
        check("b_done", b_done, 64'(1) << g);
        check("b_ready_done", b_ready, 0);
        cyc();
        check("b_done_pulse", b_done, 0);
        check("b_idle", b_active, 0);
    endtask

    initial begin
        a_valid = '0;
        a_busy  = 1'b0;
        b_valid = '0;
        b_busy  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_instr[i] = {3'(i + 1), 2'(i), 32'hA000_0000 + 32'(i)};
            a_conf[i]  = {16'(4 + i), 8'(2 + i)};
        end
        for (int i = 0; i < 3; i++) begin
            b_instr[i] = {3'(i + 4), 2'(i), 32'hB000_0010 + 32'(i)};
            b_conf[i]  = {16'(8 + i), 8'(5 + i)};
        end
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("rst_a_owner", a_owner, 0);
        check("rst_a_instr", a_linstr, 0);
        check("rst_a_conf", a_lconf, 0);
        check("rst_a_start", a_start, 0);
        check("rst_a_active", a_active, 0);
        check("rst_a_done", a_done, 0);
        check("rst_b_instr", b_linstr, 0);
        check("rst_b_active", b_active, 0);

        // Single request, LSU busy for 5 cycles; outputs hold afterwards.
        a_valid = 2'b01;
        a_txn(0, 5);
        a_valid = 2'b00;
        #1;
        check("a_hold_instr", a_linstr, a_instr[0]);
        check("a_hold_owner", a_owner, 0);

        // External busy in IDLE blocks the grant until it drops.
        cyc();
        a_valid = 2'b11;
        a_busy  = 1'b1;
        #1;
        check("a_ext_busy_ready", a_ready, 0);
        cyc();
        check("a_ext_busy_start", a_start, 0);
        check("a_ext_busy_active", a_active, 0);
        a_txn(1, 2);
        // Zero-latency LSU on the 2-requester arbiter.
        a_txn(0, 0);
        a_valid = 2'b00;

        // Round-robin fairness with all three requesters valid.
        b_valid = 3'b111;
        for (int r = 0; r < 6; r++) b_txn(r % 3, 2);

        // Non-power-of-two wrap: after owner 2 the pointer returns to 0.
        b_valid = 3'b001;
        b_txn(0, 1);
        b_valid = 3'b100;
        b_txn(2, 1);
        b_valid = 3'b101;
        b_txn(0, 1);

        // Zero-latency then a normal grant right after.
        b_valid = 3'b011;
        b_txn(1, 0);
        b_txn(0, 1);

        // Reset mid-RUN abandons owner 1 and clears the pointer.
        b_valid = 3'b010;
        b_busy  = 1'b0;
        #1;
        check("b_rr_ready", b_ready, 3'b010);
        cyc();
        b_valid = 3'b000;
        check("b_rr_start", b_start, 1);
        b_busy = 1'b1;
        cyc();
        cyc();
        #1;
        check("b_run_active", b_active, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        b_busy = 1'b0;
        #1;
        check("rstrun_done", b_done, 0);
        check("rstrun_active", b_active, 0);
        check("rstrun_owner", b_owner, 0);
        check("rstrun_instr", b_linstr, 0);
        check("rstrun_conf", b_lconf, 0);
        check("rstrun_start", b_start, 0);
        b_valid = 3'b111;
        b_txn(0, 2);
        b_valid = 3'b000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
